// File: rtl/mhd_pkg.sv
// Shared types and mask helpers for the Hamming-distance pattern generator.
package mhd_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_EMIT = 1'b1
    } state_t;

    // Lowest mask with hd ones: (1<<hd)-1, computed wide so hd=32 works.
    function automatic logic [31:0] first_mask(input int hd);
        logic [63:0] m;
        m = (64'd1 << hd) - 64'd1;
        return 32'(m);
    endfunction

    // Highest mask with hd ones inside a width-bit field.
    function automatic logic [31:0] last_mask(input int hd, input int width);
        logic [63:0] m;
        m = ((64'd1 << hd) - 64'd1) << (width - hd);
        return 32'(m);
    endfunction

endpackage

// File: rtl/mhd_ctz.sv
// Count-trailing-zeros priority encoder; result is 0 for an all-zero input.
module mhd_ctz #(
    parameter int WIDTH = 16,
    parameter int CW    = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] vec,
    output logic [CW-1:0]    tz
);

    // Scanning downwards leaves the lowest set bit as the final winner.
    always_comb begin
        tz = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (vec[i]) tz = CW'(i);
        end
    end

endmodule

// File: rtl/mhd_pattern_gen.sv
// Emits every (base, base^mask) pair with popcount(mask)==hd, masks ascending.
// Registered outputs; one pair per cycle while out_ready is high.
module mhd_pattern_gen
    import mhd_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int HD_W  = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] base,
    input  logic [HD_W-1:0]  hd,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_a,
    output logic [WIDTH-1:0] out_b,
    output logic             out_last,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             done,
    output logic             err
);

    localparam int CW = $clog2(WIDTH);

    state_t           state, state_nxt;
    logic [WIDTH-1:0] base_q;
    logic [WIDTH-1:0] mask;
    logic [HD_W-1:0]  hd_q;
    logic [WIDTH-1:0] first_m;
    logic [WIDTH-1:0] last_m;
    logic [WIDTH-1:0] low_bit;
    logic [WIDTH-1:0] ripple;
    logic [WIDTH-1:0] mask_nxt;
    logic [CW-1:0]    tz;
    logic             hd_bad;
    logic             last_hit;
    logic             fire;

    assign first_m  = WIDTH'(first_mask(int'(hd)));
    assign last_m   = WIDTH'(last_mask(int'(hd_q), WIDTH));
    assign hd_bad   = int'(hd) > WIDTH;
    assign last_hit = (mask == last_m);
    assign fire     = (state == ST_EMIT) && out_ready;

    mhd_ctz #(.WIDTH(WIDTH), .CW(CW)) u_ctz (
        .vec (mask),
        .tz  (tz)
    );

    // Gosper's step: never applied to the last mask, so no carry is lost.
    assign low_bit  = mask & (~mask + 1'b1);
    assign ripple   = mask + low_bit;
    assign mask_nxt = (((ripple ^ mask) >> 2) >> tz) | ripple;

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (start && !hd_bad) state_nxt = ST_EMIT;
            ST_EMIT: if (out_ready && last_hit) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            base_q <= '0;
            hd_q   <= '0;
            mask   <= '0;
            count  <= '0;
            done   <= 1'b0;
            err    <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            if (state == ST_IDLE) begin
                if (start && hd_bad) begin
                    err <= 1'b1;
                end else if (start) begin
                    base_q <= base;
                    hd_q   <= hd;
                    mask   <= first_m;
                    count  <= '0;
                end
            end else if (fire) begin
                count <= count + 1'b1;
                if (last_hit) begin
                    done <= 1'b1;
                end else begin
                    mask <= mask_nxt;
                end
            end
        end
    end

    assign out_valid = (state == ST_EMIT);
    assign busy      = (state != ST_IDLE);
    assign out_a     = base_q;
    assign out_b     = base_q ^ mask;
    assign out_last  = out_valid && last_hit;

endmodule

// File: tb/tb_mhd_pattern_gen.sv
// Randomised self-checking bench for mhd_pattern_gen against a popcount-filter model.
module tb_mhd_pattern_gen;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] base;
    logic [4:0]  hd;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_a;
    logic [15:0] out_b;
    logic        out_last;
    logic [15:0] count;
    logic        busy;
    logic        done;
    logic        err;

    int pass_cnt = 0;
    int total_cnt = 0;

    logic [15:0] exp_masks[$];
    logic [15:0] got_a[$];
    logic [15:0] got_b[$];
    logic [15:0] got_cnt[$];
    bit          got_last[$];
    bit          done_flag;
    bit          busy_flag;
    bit          tmo;

    mhd_pattern_gen #(.WIDTH(16), .HD_W(5)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .base      (base),
        .hd        (hd),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_a     (out_a),
        .out_b     (out_b),
        .out_last  (out_last),
        .count     (count),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: every 16-bit value with hd ones, in ascending order.
    task automatic build_model(input int h);
        exp_masks.delete();
        for (int v = 0; v < 65536; v++) begin
            if ($countones(16'(v)) == h) exp_masks.push_back(16'(v));
        end
    endtask

    task automatic do_start(input logic [15:0] b, input logic [4:0] h);
        start = 1'b1;
        base  = b;
        hd    = h;
        step();
        start = 1'b0;
    endtask

    // Drains the current run, recording every accepted pair.
    task automatic collect(input int pct);
        got_a.delete();
        got_b.delete();
        got_cnt.delete();
        got_last.delete();
        done_flag = 1'b0;
        busy_flag = 1'b1;
        tmo       = 1'b1;
        for (int cyc = 0; cyc < 8000; cyc++) begin
            out_ready = (int'($urandom_range(99)) < pct);
            if (out_valid && out_ready) begin
                got_a.push_back(out_a);
                got_b.push_back(out_b);
                got_cnt.push_back(count);
                got_last.push_back(out_last);
                if (out_last) begin
                    step();
                    done_flag = done;
                    busy_flag = busy;
                    tmo       = 1'b0;
                    out_ready = 1'b0;
                    return;
                end
            end
            step();
        end
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step();
        step();
        total_cnt++; if (out_valid !== 1'b0) $display("FAIL rst_valid got=%b want=0", out_valid); else pass_cnt++;
        total_cnt++; if (out_a !== 16'h0) $display("FAIL rst_a got=%h want=0000", out_a); else pass_cnt++;
        total_cnt++; if (out_b !== 16'h0) $display("FAIL rst_b got=%h want=0000", out_b); else pass_cnt++;
        total_cnt++; if (out_last !== 1'b0) $display("FAIL rst_last got=%b want=0", out_last); else pass_cnt++;
        total_cnt++; if (count !== 16'h0) $display("FAIL rst_count got=%h want=0000", count); else pass_cnt++;
        total_cnt++; if ({busy, done, err} !== 3'b000) $display("FAIL rst_flags got=%b want=000", {busy, done, err}); else pass_cnt++;
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_hd1();
        build_model(1);
        do_start(16'h0000, 5'd1);
        total_cnt++; if (out_valid !== 1'b1) $display("FAIL hd1_latency got=%b want=1", out_valid); else pass_cnt++;
        collect(100);
        total_cnt++; if (tmo !== 1'b0) $display("FAIL hd1_timeout got=%b want=0", tmo); else pass_cnt++;
        total_cnt++; if (got_b.size() !== 16) $display("FAIL hd1_pairs got=%0d want=16", got_b.size()); else pass_cnt++;
        for (int i = 0; i < got_b.size() && i < 16; i++) begin
            total_cnt++; if (got_b[i] !== exp_masks[i]) $display("FAIL hd1_b[%0d] got=%h want=%h", i, got_b[i], exp_masks[i]); else pass_cnt++;
            total_cnt++; if (got_last[i] !== (i == 15)) $display("FAIL hd1_last[%0d] got=%b want=%b", i, got_last[i], i == 15); else pass_cnt++;
            total_cnt++; if (got_cnt[i] !== 16'(i)) $display("FAIL hd1_count[%0d] got=%0d want=%0d", i, got_cnt[i], i); else pass_cnt++;
        end
        total_cnt++; if (done_flag !== 1'b1) $display("FAIL hd1_done got=%b want=1", done_flag); else pass_cnt++;
        total_cnt++; if (busy_flag !== 1'b0) $display("FAIL hd1_busy got=%b want=0", busy_flag); else pass_cnt++;
        total_cnt++; if (count !== 16'd16) $display("FAIL hd1_final_count got=%0d want=16", count); else pass_cnt++;
        step();
        total_cnt++; if (done !== 1'b0) $display("FAIL hd1_done_pulse got=%b want=0", done); else pass_cnt++;
    endtask

    task automatic test_hd2();
        logic [15:0] m;
        logic [15:0] prev;
        build_model(2);
        do_start(16'hA5A5, 5'd2);
        collect(100);
        total_cnt++; if (tmo !== 1'b0) $display("FAIL hd2_timeout got=%b want=0", tmo); else pass_cnt++;
        total_cnt++; if (got_b.size() !== 120) $display("FAIL hd2_pairs got=%0d want=120", got_b.size()); else pass_cnt++;
        prev = 16'h0;
        for (int i = 0; i < got_b.size() && i < 120; i++) begin
            m = got_a[i] ^ got_b[i];
            total_cnt++; if (got_a[i] !== 16'hA5A5) $display("FAIL hd2_a[%0d] got=%h want=a5a5", i, got_a[i]); else pass_cnt++;
            total_cnt++; if (m !== exp_masks[i]) $display("FAIL hd2_mask[%0d] got=%h want=%h", i, m, exp_masks[i]); else pass_cnt++;
            total_cnt++; if ($countones(m) !== 2) $display("FAIL hd2_pop[%0d] got=%0d want=2", i, $countones(m)); else pass_cnt++;
            total_cnt++; if (!(m > prev)) $display("FAIL hd2_order[%0d] got=%h want_above=%h", i, m, prev); else pass_cnt++;
            prev = m;
        end
        total_cnt++; if (prev !== 16'hC000) $display("FAIL hd2_lastmask got=%h want=c000", prev); else pass_cnt++;
        total_cnt++; if (done_flag !== 1'b1) $display("FAIL hd2_done got=%b want=1", done_flag); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        do_start(16'h1E3C, 5'd0);
        collect(100);
        total_cnt++; if (got_b.size() !== 1) $display("FAIL hd0_pairs got=%0d want=1", got_b.size()); else pass_cnt++;
        if (got_b.size() > 0) begin
            total_cnt++; if ({got_a[0], got_b[0]} !== {16'h1E3C, 16'h1E3C}) $display("FAIL hd0_ab got=%h/%h want=1e3c/1e3c", got_a[0], got_b[0]); else pass_cnt++;
            total_cnt++; if (got_last[0] !== 1'b1) $display("FAIL hd0_last got=%b want=1", got_last[0]); else pass_cnt++;
        end
        total_cnt++; if ({done_flag, busy_flag} !== 2'b10) $display("FAIL hd0_done_busy got=%b want=10", {done_flag, busy_flag}); else pass_cnt++;
        // start issued in the done cycle must be taken
        do_start(16'h5A5A, 5'd16);
        total_cnt++; if (out_valid !== 1'b1) $display("FAIL b2b_accept got=%b want=1", out_valid); else pass_cnt++;
        collect(100);
        total_cnt++; if (got_b.size() !== 1) $display("FAIL hd16_pairs got=%0d want=1", got_b.size()); else pass_cnt++;
        if (got_b.size() > 0) begin
            total_cnt++; if (got_b[0] !== 16'hA5A5) $display("FAIL hd16_b got=%h want=a5a5", got_b[0]); else pass_cnt++;
            total_cnt++; if (got_last[0] !== 1'b1) $display("FAIL hd16_last got=%b want=1", got_last[0]); else pass_cnt++;
        end
        total_cnt++; if (done_flag !== 1'b1) $display("FAIL hd16_done got=%b want=1", done_flag); else pass_cnt++;
    endtask

    task automatic test_err();
        step();
        do_start(16'hFFFF, 5'd17);
        total_cnt++; if (err !== 1'b1) $display("FAIL err_pulse got=%b want=1", err); else pass_cnt++;
        total_cnt++; if ({out_valid, busy} !== 2'b00) $display("FAIL err_idle got=%b want=00", {out_valid, busy}); else pass_cnt++;
        step();
        total_cnt++; if (err !== 1'b0) $display("FAIL err_clear got=%b want=0", err); else pass_cnt++;
        total_cnt++; if ({out_valid, busy} !== 2'b00) $display("FAIL err_stay got=%b want=00", {out_valid, busy}); else pass_cnt++;
    endtask

    task automatic test_random_ready();
        bit          stalled;
        bit          fin;
        logic [15:0] sa, sb, sc;
        bit          sl;
        stalled = 1'b0;
        fin     = 1'b0;
        sa = '0; sb = '0; sc = '0; sl = 1'b0;
        got_b.delete();
        build_model(4);
        do_start(16'h3C5A, 5'd4);
        for (int cyc = 0; cyc < 10000 && !fin; cyc++) begin
            if (stalled) begin
                total_cnt++;
                if ({out_a, out_b, out_last, count} !== {sa, sb, sl, sc})
                    $display("FAIL stall_hold got=%h/%h/%b/%0d want=%h/%h/%b/%0d", out_a, out_b, out_last, count, sa, sb, sl, sc);
                else pass_cnt++;
            end
            out_ready = $urandom_range(1) == 1;
            stalled = 1'b0;
            if (out_valid && out_ready) begin
                got_b.push_back(out_b);
                if (out_last) fin = 1'b1;
            end else if (out_valid) begin
                stalled = 1'b1;
                sa = out_a; sb = out_b; sl = out_last; sc = count;
            end
            step();
        end
        out_ready = 1'b0;
        total_cnt++; if (fin !== 1'b1) $display("FAIL rnd_timeout got=%b want=1", fin); else pass_cnt++;
        total_cnt++; if (got_b.size() !== 1820) $display("FAIL rnd_pairs got=%0d want=1820", got_b.size()); else pass_cnt++;
        for (int i = 0; i < got_b.size() && i < 1820; i++) begin
            total_cnt++; if ((got_b[i] ^ 16'h3C5A) !== exp_masks[i]) $display("FAIL rnd_mask[%0d] got=%h want=%h", i, got_b[i] ^ 16'h3C5A, exp_masks[i]); else pass_cnt++;
        end
        total_cnt++; if (done !== 1'b1) $display("FAIL rnd_done got=%b want=1", done); else pass_cnt++;
        total_cnt++; if (count !== 16'd1820) $display("FAIL rnd_count got=%0d want=1820", count); else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        step();
        do_start(16'h1234, 5'd3);
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) step();
        total_cnt++; if (count !== 16'd10) $display("FAIL mid_count got=%0d want=10", count); else pass_cnt++;
        rst_n     = 1'b0;
        out_ready = 1'b0;
        step();
        total_cnt++; if ({out_valid, busy, done} !== 3'b000) $display("FAIL mid_flags got=%b want=000", {out_valid, busy, done}); else pass_cnt++;
        total_cnt++; if (count !== 16'd0) $display("FAIL mid_rst_count got=%0d want=0", count); else pass_cnt++;
        total_cnt++; if ({out_a, out_b} !== 32'h0) $display("FAIL mid_rst_ab got=%h/%h want=0000/0000", out_a, out_b); else pass_cnt++;
        rst_n = 1'b1;
        step();
        total_cnt++; if (done !== 1'b0) $display("FAIL mid_no_done got=%b want=0", done); else pass_cnt++;
        do_start(16'h1234, 5'd3);
        total_cnt++; if ((out_a ^ out_b) !== 16'h0007) $display("FAIL mid_restart_mask got=%h want=0007", out_a ^ out_b); else pass_cnt++;
        total_cnt++; if ({out_valid, count} !== {1'b1, 16'd0}) $display("FAIL mid_restart got=%b/%0d want=1/0", out_valid, count); else pass_cnt++;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();
    endtask

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        base      = '0;
        hd        = '0;
        out_ready = 1'b0;
        test_reset();
        test_hd1();
        test_hd2();
        test_back_to_back();
        test_err();
        test_random_ready();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
